// File: rtl/vector_writeback_arbiter.sv
// Writeback arbiter: merges ALU and FIFO-buffered LSU results into one registered RF write per cycle.
// Optional VWB_PERF_EN adds saturating ALU-stall and FIFO-full cycle counters.
module vector_writeback_arbiter #(
    parameter int THREADS = 4,
    parameter int DEPTH   = 4
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [4:0]                alu_wsel,
    input  logic [THREADS-1:0]        alu_mask,
    input  logic [THREADS*32-1:0]     alu_wdata,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [4:0]                lsu_wsel,
    input  logic [THREADS-1:0]        lsu_mask,
    input  logic [THREADS*32-1:0]     lsu_wdata,
    output logic [THREADS-1:0]        rf_wen,
    output logic [4:0]                rf_wsel,
    output logic [THREADS*32-1:0]     rf_wdata,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      busy
`ifdef VWB_PERF_EN
    ,
    output logic [31:0]               alu_stall_cnt,
    output logic [31:0]               fifo_full_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    // Handshake: a transfer happens on valid && ready at the rising edge;
    // producers keep their payload stable while valid is high and ready is low.
    logic [4:0]            r_fifo_wsel [DEPTH];
    logic [THREADS-1:0]    r_fifo_mask [DEPTH];
    logic [THREADS*32-1:0] r_fifo_data [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [THREADS-1:0]    r_wen;
    logic [4:0]            r_wsel;
    logic [THREADS*32-1:0] r_wdata;

    logic          w_empty;
    logic          w_full;
    logic          w_hazard;
    logic          w_pop;
    logic          w_push;
    logic          w_alu_take;
    logic [AW-1:0] w_offset;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));

    // Only live entries (offset from head below occupancy) can cause a WAW hazard.
    always_comb begin
        w_hazard = 1'b0;
        w_offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_offset = AW'(i) - r_rd_ptr;
            if (({1'b0, w_offset} < r_count) && (r_fifo_wsel[i] == alu_wsel) &&
                ((r_fifo_mask[i] & alu_mask) != '0)) begin
                w_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        alu_ready = 1'b1;
        w_pop     = 1'b0;
        if (!w_empty) begin
            if (w_hazard || w_full) begin
                alu_ready = 1'b0;
                w_pop     = 1'b1;
            end else begin
                w_pop = !alu_valid;
            end
        end
    end

    assign w_alu_take = alu_valid && alu_ready;
    assign lsu_ready  = !w_full;
    assign w_push     = lsu_valid && !w_full;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_wsel[r_wr_ptr] <= lsu_wsel;
            r_fifo_mask[r_wr_ptr] <= lsu_mask;
            r_fifo_data[r_wr_ptr] <= lsu_wdata;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // A mask-0 grant still loads wsel/wdata; only the enables stay low.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wen   <= '0;
            r_wsel  <= '0;
            r_wdata <= '0;
        end else if (w_alu_take) begin
            r_wen   <= alu_mask;
            r_wsel  <= alu_wsel;
            r_wdata <= alu_wdata;
        end else if (w_pop) begin
            r_wen   <= r_fifo_mask[r_rd_ptr];
            r_wsel  <= r_fifo_wsel[r_rd_ptr];
            r_wdata <= r_fifo_data[r_rd_ptr];
        end else begin
            r_wen <= '0;
        end
    end

    assign rf_wen     = r_wen;
    assign rf_wsel    = r_wsel;
    assign rf_wdata   = r_wdata;
    assign fifo_count = r_count;
    assign busy       = (r_count != '0) || (r_wen != '0);

`ifdef VWB_PERF_EN
    logic [31:0] r_alu_stall_cnt;
    logic [31:0] r_fifo_full_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_alu_stall_cnt <= '0;
            r_fifo_full_cnt <= '0;
        end else begin
            if (alu_valid && !alu_ready && (r_alu_stall_cnt != 32'hFFFF_FFFF))
                r_alu_stall_cnt <= r_alu_stall_cnt + 1'b1;
            if (w_full && (r_fifo_full_cnt != 32'hFFFF_FFFF))
                r_fifo_full_cnt <= r_fifo_full_cnt + 1'b1;
        end
    end

    assign alu_stall_cnt = r_alu_stall_cnt;
    assign fifo_full_cnt = r_fifo_full_cnt;
`endif
endmodule

// File: tb/tb_vector_writeback_arbiter.sv
// Bench for vector_writeback_arbiter: directed vector table, reset corner, and a
// randomized run checked cycle-by-cycle against a queue-based reference model.
module tb_vector_writeback_arbiter;
    localparam int THREADS = 4;
    localparam int DEPTH   = 4;
    localparam int W       = 5 + THREADS + THREADS*32;

    logic         CLK;
    logic         nRST;
    logic         alu_valid;
    logic         alu_ready;
    logic [4:0]   alu_wsel;
    logic [3:0]   alu_mask;
    logic [127:0] alu_wdata;
    logic         lsu_valid;
    logic         lsu_ready;
    logic [4:0]   lsu_wsel;
    logic [3:0]   lsu_mask;
    logic [127:0] lsu_wdata;
    logic [3:0]   rf_wen;
    logic [4:0]   rf_wsel;
    logic [127:0] rf_wdata;
    logic [2:0]   fifo_count;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    vector_writeback_arbiter #(.THREADS(THREADS), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wsel(alu_wsel),
        .alu_mask(alu_mask), .alu_wdata(alu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wsel(lsu_wsel),
        .lsu_mask(lsu_mask), .lsu_wdata(lsu_wdata),
        .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata),
        .fifo_count(fifo_count), .busy(busy)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic         av;
        logic [4:0]   aw;
        logic [3:0]   am;
        logic [127:0] ad;
        logic         lv;
        logic [4:0]   lw;
        logic [3:0]   lm;
        logic [127:0] ld;
        logic         e_ar;
        logic         e_lr;
        logic [3:0]   e_wen;
        logic [4:0]   e_wsel;
        logic [127:0] e_wdata;
        logic [2:0]   e_cnt;
    } vec_t;

    vec_t vecs[18];

    // Reference model state: queued LSU entries {wsel, mask, data} plus the output register
    logic [W-1:0] exp_q[$];
    logic [3:0]   m_wen;
    logic [4:0]   m_wsel;
    logic [127:0] m_wdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aw, input logic [3:0] am,
                                input logic [127:0] ad, input logic lv, input logic [4:0] lw,
                                input logic [3:0] lm, input logic [127:0] ld, input logic e_ar,
                                input logic e_lr, input logic [3:0] e_wen, input logic [4:0] e_wsel,
                                input logic [127:0] e_wdata, input logic [2:0] e_cnt);
        vec_t v;
        v.av = av; v.aw = aw; v.am = am; v.ad = ad;
        v.lv = lv; v.lw = lw; v.lm = lm; v.ld = ld;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_wen = e_wen; v.e_wsel = e_wsel;
        v.e_wdata = e_wdata; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive(input logic av, input logic [4:0] aw, input logic [3:0] am,
                         input logic [127:0] ad, input logic lv, input logic [4:0] lw,
                         input logic [3:0] lm, input logic [127:0] ld);
        alu_valid = av; alu_wsel = aw; alu_mask = am; alu_wdata = ad;
        lsu_valid = lv; lsu_wsel = lw; lsu_mask = lm; lsu_wdata = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 4'd0, 128'd0, 1'b0, 5'd0, 4'd0, 128'd0);
    endtask

    initial begin
        logic [127:0] da, l5, de, df, dg, dh, p0, p1, p2, p3, z;
        logic         m_haz, m_pop, exp_ar, exp_lr, a_acc, l_acc;
        logic [W-1:0] e;
        int           alu_pct, lsu_pct;

        da = {32'hD, 32'hC, 32'hB, 32'hA};
        l5 = {4{32'h5555_0005}};
        de = {4{32'hEEEE_0007}};
        df = {4{32'hFFFF_0007}};
        dg = {4{32'h6666_0009}};
        dh = {4{32'h1111_0001}};
        p0 = {4{32'h1000_0000}};
        p1 = {4{32'h1000_0001}};
        p2 = {4{32'h1000_0002}};
        p3 = {4{32'h1000_0003}};
        z  = 128'd0;

        //               alu: v  wsel   mask     data lsu: v  wsel    mask     data  ar    lr    wen      wsel   wdata cnt
        vecs[0]  = mk(1'b1, 5'd3,  4'b1011, da, 1'b0, 5'd0,  4'b0000, z,  1'b1, 1'b1, 4'b1011, 5'd3,  da, 3'd0);
        vecs[1]  = mk(1'b0, 5'd0,  4'b0000, z,  1'b0, 5'd0,  4'b0000, z,  1'b1, 1'b1, 4'b0000, 5'd3,  da, 3'd0);
        vecs[2]  = mk(1'b0, 5'd0,  4'b0000, z,  1'b1, 5'd5,  4'b1111, l5, 1'b1, 1'b1, 4'b0000, 5'd3,  da, 3'd1);
        vecs[3]  = mk(1'b0, 5'd0,  4'b0000, z,  1'b0, 5'd0,  4'b0000, z,  1'b1, 1'b1, 4'b1111, 5'd5,  l5, 3'd0);
        vecs[4]  = mk(1'b0, 5'd0,  4'b0000, z,  1'b1, 5'd7,  4'b0001, de, 1'b1, 1'b1, 4'b0000, 5'd5,  l5, 3'd1);
        vecs[5]  = mk(1'b1, 5'd7,  4'b0011, df, 1'b0, 5'd0,  4'b0000, z,  1'b0, 1'b1, 4'b0001, 5'd7,  de, 3'd0);
        vecs[6]  = mk(1'b1, 5'd7,  4'b0011, df, 1'b0, 5'd0,  4'b0000, z,  1'b1, 1'b1, 4'b0011, 5'd7,  df, 3'd0);
        vecs[7]  = mk(1'b1, 5'd9,  4'b0000, dg, 1'b0, 5'd0,  4'b0000, z,  1'b1, 1'b1, 4'b0000, 5'd9,  dg, 3'd0);
        vecs[8]  = mk(1'b1, 5'd1,  4'b0001, dh, 1'b1, 5'd10, 4'b1111, p0, 1'b1, 1'b1, 4'b0001, 5'd1,  dh, 3'd1);
        vecs[9]  = mk(1'b1, 5'd1,  4'b0001, dh, 1'b1, 5'd11, 4'b1111, p1, 1'b1, 1'b1, 4'b0001, 5'd1,  dh, 3'd2);
        vecs[10] = mk(1'b1, 5'd1,  4'b0001, dh, 1'b1, 5'd12, 4'b1111, p2, 1'b1, 1'b1, 4'b0001, 5'd1,  dh, 3'd3);
        vecs[11] = mk(1'b1, 5'd1,  4'b0001, dh, 1'b1, 5'd13, 4'b1111, p3, 1'b1, 1'b1, 4'b0001, 5'd1,  dh, 3'd4);
        vecs[12] = mk(1'b1, 5'd1,  4'b0001, dh, 1'b0, 5'd0,  4'b0000, z,  1'b0, 1'b0, 4'b1111, 5'd10, p0, 3'd3);
        vecs[13] = mk(1'b1, 5'd1,  4'b0001, dh, 1'b0, 5'd0,  4'b0000, z,  1'b1, 1'b1, 4'b0001, 5'd1,  dh, 3'd3);
        vecs[14] = mk(1'b0, 5'd0,  4'b0000, z,  1'b0, 5'd0,  4'b0000, z,  1'b1, 1'b1, 4'b1111, 5'd11, p1, 3'd2);
        vecs[15] = mk(1'b0, 5'd0,  4'b0000, z,  1'b0, 5'd0,  4'b0000, z,  1'b1, 1'b1, 4'b1111, 5'd12, p2, 3'd1);
        vecs[16] = mk(1'b0, 5'd0,  4'b0000, z,  1'b0, 5'd0,  4'b0000, z,  1'b1, 1'b1, 4'b1111, 5'd13, p3, 3'd0);
        vecs[17] = mk(1'b0, 5'd0,  4'b0000, z,  1'b0, 5'd0,  4'b0000, z,  1'b1, 1'b1, 4'b0000, 5'd13, p3, 3'd0);

        // Reset state
        nRST = 1'b0;
        idle();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_wen", 128'(rf_wen), 128'd0);
        chk("reset_wsel", 128'(rf_wsel), 128'd0);
        chk("reset_wdata", rf_wdata, 128'd0);
        chk("reset_count", 128'(fifo_count), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            drive(vecs[i].av, vecs[i].aw, vecs[i].am, vecs[i].ad,
                  vecs[i].lv, vecs[i].lw, vecs[i].lm, vecs[i].ld);
            #1;
            chk($sformatf("vec%0d_alu_ready", i), 128'(alu_ready), 128'(vecs[i].e_ar));
            chk($sformatf("vec%0d_lsu_ready", i), 128'(lsu_ready), 128'(vecs[i].e_lr));
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_wen", i), 128'(rf_wen), 128'(vecs[i].e_wen));
            chk($sformatf("vec%0d_wsel", i), 128'(rf_wsel), 128'(vecs[i].e_wsel));
            chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].e_wdata);
            chk($sformatf("vec%0d_count", i), 128'(fifo_count), 128'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_busy", i), 128'(busy),
                128'((vecs[i].e_cnt != 0) || (vecs[i].e_wen != 0)));
        end

        // Reset asserted mid-stream with three entries queued
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            drive(1'b1, 5'd2, 4'b0001, dh, 1'b1, 5'(20 + k), 4'b1111, p0);
            @(posedge CLK);
        end
        #1;
        chk("midrst_pre_count", 128'(fifo_count), 128'd3);
        @(negedge CLK);
        idle();
        nRST = 1'b0;
        #1;
        chk("midrst_count", 128'(fifo_count), 128'd0);
        chk("midrst_wen", 128'(rf_wen), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_wsel", 128'(rf_wsel), 128'd0);
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("postrst%0d_wen", k), 128'(rf_wen), 128'd0);
            chk($sformatf("postrst%0d_count", k), 128'(fifo_count), 128'd0);
        end

        // Randomized run against the reference model (DUT and model both empty here)
        exp_q.delete();
        m_wen = '0; m_wsel = '0; m_wdata = '0;
        a_acc = 1'b1; l_acc = 1'b1;
        alu_pct = 50; lsu_pct = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) begin
                alu_pct = $urandom_range(20, 95);
                lsu_pct = $urandom_range(10, 95);
            end
            @(negedge CLK);
            if (!(alu_valid && !a_acc)) begin
                alu_valid = ($urandom_range(0, 99) < alu_pct);
                alu_wsel  = 5'($urandom_range(0, 3));
                alu_mask  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
                alu_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!(lsu_valid && !l_acc)) begin
                lsu_valid = ($urandom_range(0, 99) < lsu_pct);
                lsu_wsel  = 5'($urandom_range(0, 3));
                lsu_mask  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
                lsu_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            m_haz = 1'b0;
            foreach (exp_q[j])
                if (exp_q[j][W-1 -: 5] == alu_wsel && (exp_q[j][131:128] & alu_mask) != 4'd0)
                    m_haz = 1'b1;
            if (exp_q.size() == 0) exp_ar = 1'b1;
            else                   exp_ar = !(m_haz || exp_q.size() == DEPTH);
            exp_lr = (exp_q.size() != DEPTH);
            m_pop  = (exp_q.size() != 0) && (m_haz || exp_q.size() == DEPTH || !alu_valid);
            a_acc  = alu_valid && exp_ar;
            l_acc  = lsu_valid && exp_lr;
            #1;
            chk($sformatf("rnd%0d_alu_ready", cyc), 128'(alu_ready), 128'(exp_ar));
            chk($sformatf("rnd%0d_lsu_ready", cyc), 128'(lsu_ready), 128'(exp_lr));
            @(posedge CLK);
            if (a_acc) begin
                m_wen = alu_mask; m_wsel = alu_wsel; m_wdata = alu_wdata;
            end else if (m_pop) begin
                e = exp_q.pop_front();
                m_wsel = e[W-1 -: 5]; m_wen = e[131:128]; m_wdata = e[127:0];
            end else begin
                m_wen = '0;
            end
            if (l_acc) exp_q.push_back({lsu_wsel, lsu_mask, lsu_wdata});
            #1;
            chk($sformatf("rnd%0d_wen", cyc), 128'(rf_wen), 128'(m_wen));
            chk($sformatf("rnd%0d_wsel", cyc), 128'(rf_wsel), 128'(m_wsel));
            chk($sformatf("rnd%0d_wdata", cyc), rf_wdata, m_wdata);
            chk($sformatf("rnd%0d_count", cyc), 128'(fifo_count), 128'(exp_q.size()));
            chk($sformatf("rnd%0d_busy", cyc), 128'(busy), 128'(exp_q.size() != 0 || m_wen != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
